// File: rtl/gat_feat_bram_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : gat_feat_bram_reader_if
// Purpose  : Bundles the feature-BRAM read port and the outgoing AXI-Stream
//            style channel of the GAT feature reader into one interface.
// Signals  : feat_bram_addrb  byte address to the feature BRAM read port
//            feat_bram_dout   BRAM read data (fixed latency after addrb)
//            m_tdata          stream data
//            m_tvalid         stream valid
//            m_tready         stream ready (from the sink)
//            m_tlast          stream packet end marker
// Modports : master - the reader (drives addrb and the stream)
//            slave  - the BRAM/sink side (drives dout and ready)
// Revision : 1.0 - initial release
// ============================================================================
interface gat_feat_bram_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18
);

  logic [ADDR_W-1:0] feat_bram_addrb;
  logic [DATA_W-1:0] feat_bram_dout;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    output feat_bram_addrb,
    input  feat_bram_dout,
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  feat_bram_addrb,
    output feat_bram_dout,
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );

endinterface
`default_nettype wire

// File: rtl/gat_feat_bram_reader.sv
`default_nettype none
// ============================================================================
// Module   : gat_feat_bram_reader
// Purpose  : Read-side master for the GAT new-feature BRAM. On start it sweeps
//            every output feature word, absorbs the fixed BRAM read latency
//            and streams the words out with valid/ready and tlast. Reads are
//            credit-limited so backpressure never drops data.
// Ports    : clk       in   single clock
//            rst_n     in   asynchronous active-low reset
//            start     in   1-cycle pulse, begins a sweep when idle
//            busy      out  high while a sweep is in progress
//            done      out  1-cycle pulse after the last beat is accepted
//            bus       if   master modport: feat_bram_addrb/feat_bram_dout,
//                           m_tdata/m_tvalid/m_tready/m_tlast
// Config   : FEAT_RD_NODE_TLAST_EN - when defined, m_tlast marks the last
//            feature of every node (one packet per node); otherwise m_tlast
//            marks only the final word of the sweep.
// Revision : 1.0 - initial release
// ============================================================================
module gat_feat_bram_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int FIFO_DEPTH         = BRAM_RD_LATENCY + 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  start,
  output logic busy,
  output logic done,
  gat_feat_bram_reader_if.master bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  // One extra index bit so rd_idx can reach DEPTH even when DEPTH is a power
  // of two.
  localparam int c_idx_w = NEW_FEATURE_ADDR_W + 1;
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1) + 1;

  localparam logic [c_idx_w-1:0] c_depth      = c_idx_w'(NEW_FEATURE_DEPTH);
  localparam logic [c_idx_w-1:0] c_last_beat  = c_idx_w'(NEW_FEATURE_DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_fifo_depth = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last   = c_ptr_w'(FIFO_DEPTH - 1);

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [c_idx_w-1:0]              r_rd_idx;
  logic [c_idx_w-1:0]              r_beat_cnt;
  logic [NEW_FEATURE_ADDR_W+1:0]   r_addrb;
  // Stage 0 lines up with the registered addrb, stage BRAM_RD_LATENCY lines
  // up with the matching word on feat_bram_dout.
  logic [BRAM_RD_LATENCY:0]        r_vld_pipe;
  logic [c_cnt_w-1:0]              r_inflight;

  logic [NEW_FEATURE_WIDTH-1:0]    r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]              r_wr_ptr;
  logic [c_ptr_w-1:0]              r_rd_ptr;
  logic [c_cnt_w-1:0]              r_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic               w_start_acc;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_tvalid;
  logic               w_last_beat;
  logic [c_cnt_w-1:0] w_used;
  logic [c_ptr_w-1:0] w_wr_ptr_nxt;
  logic [c_ptr_w-1:0] w_rd_ptr_nxt;

  assign w_tvalid    = (r_count != '0);
  assign w_pop       = w_tvalid && bus.m_tready;
  assign w_push      = r_vld_pipe[BRAM_RD_LATENCY];
  assign w_last_beat = (r_beat_cnt == c_last_beat);

  // Credits: words already buffered plus reads still in the BRAM pipe. The
  // entry leaving the FIFO this cycle returns its credit immediately, which
  // is what allows one issue per cycle when the sink is always ready.
  assign w_used  = r_count + r_inflight;
  assign w_issue = (r_state == S_RUN) && (r_rd_idx < c_depth) &&
                   ((w_used - c_cnt_w'(w_pop)) < c_fifo_depth);

  assign w_wr_ptr_nxt = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_start_acc = 1'b1;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_rd_idx == c_depth) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && w_last_beat) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read issue: word index, BRAM address and read-latency tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_idx   <= '0;
      r_addrb    <= '0;
      r_vld_pipe <= '0;
      r_inflight <= '0;
    end else begin
      if (w_start_acc) begin
        r_rd_idx <= '0;
      end else if (w_issue) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end

      // addrb keeps the last issued address between issues.
      if (w_issue) begin
        r_addrb <= {r_rd_idx[NEW_FEATURE_ADDR_W-1:0], 2'b00};
      end

      r_vld_pipe <= {r_vld_pipe[BRAM_RD_LATENCY-1:0], w_issue};
      r_inflight <= r_inflight + c_cnt_w'(w_issue) - c_cnt_w'(w_push);
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through, head drives the stream directly)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= bus.feat_bram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A push into a full FIFO means the credit accounting is broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == c_fifo_depth)));

  // --------------------------------------------------------------------------
  // Beat counting and end-of-packet marker
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_start_acc) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
    end
  end

`ifdef FEAT_RD_NODE_TLAST_EN
  // Separate feature counter avoids a modulo on the beat counter.
  localparam int c_feat_w = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [c_feat_w-1:0] c_feat_last = c_feat_w'(NUM_FEATURE_OUT - 1);

  logic [c_feat_w-1:0] r_feat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat_cnt <= '0;
    end else if (w_start_acc) begin
      r_feat_cnt <= '0;
    end else if (w_pop) begin
      r_feat_cnt <= (r_feat_cnt == c_feat_last) ? '0 : r_feat_cnt + 1'b1;
    end
  end

  assign bus.m_tlast = w_tvalid && (r_feat_cnt == c_feat_last);
`else
  assign bus.m_tlast = w_tvalid && w_last_beat;
`endif

  // --------------------------------------------------------------------------
  // Interface outputs
  // --------------------------------------------------------------------------
  assign bus.feat_bram_addrb = r_addrb;
  assign bus.m_tdata         = r_mem[r_rd_ptr];
  assign bus.m_tvalid        = w_tvalid;

endmodule
`default_nettype wire
